audio_sample_fifo: RTL
======================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 20, meaning sample word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning the number of storage entries; it is a power of two, minimum 4.
REQ-003 SHALL have parameter AF_LEVEL, default 24, meaning the occupancy at or above which almost_full asserts; its range is 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port wr_en, input, 1 bit: the write request from the sample producer (CPU MMIO or tone generator).
REQ-007 SHALL have port din, input, WIDTH bits: the sample to write.
REQ-008 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-009 SHALL have port almost_full, output, 1 bit: high when count is at least AF_LEVEL.
REQ-010 SHALL have port rd_en, input, 1 bit: the pop request from the AC97 controller sample interface.
REQ-011 SHALL have port dout, output, WIDTH bits: the oldest stored sample, first-word-fall-through.
REQ-012 SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: the current occupancy.
REQ-014 SHALL have port flush, input, 1 bit: a synchronous discard of all contents.
REQ-015 SHALL have port clr_status, input, 1 bit: a synchronous clear of overflow and underrun_cnt.
REQ-016 SHALL have port overflow, output, 1 bit: a sticky flag set by a rejected write.
REQ-017 SHALL have port underrun_cnt, output, 16 bits: a saturating count of rejected reads.

Function
REQ-018 SHALL accept a write on any cycle where wr_en=1 and either full=0, or full=1 with rd_en=1 and a read accepted that same cycle.
REQ-019 SHALL accept a read on any cycle where rd_en=1 and empty=0.
REQ-020 SHALL present the oldest entry on dout whenever empty=0, with no read latency; after an accepted read, dout shows the next entry on the following cycle.
REQ-021 SHALL make a written word visible on dout, with empty deasserted, on the cycle after the write when the FIFO was empty; no bypass is performed in the write cycle.
REQ-022 SHALL on a simultaneous accepted read and write leave count unchanged and advance both pointers.
REQ-023 SHALL when empty with rd_en=1 and wr_en=1 accept the write, reject the read and increment underrun_cnt.
REQ-024 SHALL update count as count+1 on write only, count-1 on read only, and hold it otherwise; count never exceeds DEPTH and never goes below 0.
REQ-025 SHALL use read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH without a gap.
REQ-026 SHALL derive full, empty and almost_full from registered count, so they are valid in the same cycle as count.
REQ-027 SHALL leave storage unchanged on a rejected write (wr_en=1 while full with no read) and set overflow to 1 on the next cycle.
REQ-028 SHALL on a rejected read (rd_en=1 while empty) leave pointers unchanged and increment underrun_cnt by 1, saturating at 16'hFFFF.
REQ-029 SHALL on flush=1 set the pointers and count to 0 on the next edge, with flush overriding wr_en and rd_en in that cycle; overflow and underrun_cnt are unaffected.
REQ-030 SHALL on clr_status=1 clear overflow and underrun_cnt, with a same-cycle set or increment losing to the clear.
REQ-031 SHALL leave dout undefined-but-stable (holding the RAM output at rd_ptr) when empty=1; consumers ignore it.
REQ-032 SHALL be able to map storage to distributed RAM: one write port and an asynchronous read at rd_ptr.

Reset
REQ-033 SHALL while rst_b=0 force count=0, pointers=0, empty=1, full=0, almost_full=0, overflow=0 and underrun_cnt=0, asynchronously.
REQ-034 SHALL not clear storage contents on reset.
REQ-035 SHALL resume accepting writes on the first rising edge after rst_b deasserts.
REQ-036 SHALL on reset asserted mid-burst discard all in-flight data, and the first post-reset read returns the first post-reset write.

Verification
REQ-037 SHALL be verified with: reset, write 0x00001..0x00003 on 3 cycles, then rd_en held -> dout 0x00001, 0x00002, 0x00003 on consecutive cycles, then empty=1, count=0.
REQ-038 SHALL be verified with: 32 writes, then a 33rd write of 0xABCDE -> full=1, count=32, overflow=1, the 32 reads return the original data and 0xABCDE never appears.
REQ-039 SHALL be verified with: count=32 and wr_en=rd_en=1 for 40 cycles with incrementing data -> count stays 32, full stays 1, and read order matches write order across pointer wrap.
REQ-040 SHALL be verified with: empty and rd_en=1 for 3 cycles, then clr_status -> underrun_cnt goes 1, 2, 3, then 0; empty and wr_en=rd_en=1 -> count=1 and underrun_cnt increments.
REQ-041 SHALL be verified with: fill to 23 -> almost_full=0, 24th write -> almost_full=1, one read -> almost_full=0.
REQ-042 SHALL be verified with: count=10 and flush together with wr_en -> count=0 and empty=1 next cycle; rst_b pulsed low mid-cycle at count=5 -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/audio_sample_fifo_if.sv
`default_nettype none
// ============================================================================
// audio_sample_fifo_if : sample FIFO producer/consumer/status bundle
// Rev 1.0
// ============================================================================
interface audio_sample_fifo_if #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 32
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [WIDTH-1:0]  din;
  logic              full;
  logic              almost_full;
  logic              rd_en;
  logic [WIDTH-1:0]  dout;
  logic              empty;
  logic [c_CW-1:0]   count;
  logic              flush;
  logic              clr_status;
  logic              overflow;
  logic [15:0]       underrun_cnt;

  modport master (
    output wr_en, din, rd_en, flush, clr_status,
    input  full, almost_full, dout, empty, count, overflow, underrun_cnt
  );

  modport slave (
    input  wr_en, din, rd_en, flush, clr_status,
    output full, almost_full, dout, empty, count, overflow, underrun_cnt
  );
endinterface
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// audio_sample_fifo : first-word-fall-through sample FIFO feeding the AC97 port
// Rev 1.0
// ============================================================================
module audio_sample_fifo #(
  parameter int WIDTH    = 20,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 24
) (
  input  logic               clk,
  input  logic               rst_b,
  audio_sample_fifo_if.slave bus
);

  localparam int              c_AW    = $clog2(DEPTH);
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_AF    = c_CW'(AF_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             r_overflow;
  logic [15:0]      r_underrun_cnt;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_wr_reject;
  logic w_rd_reject;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);

  // Flush swallows both requests, so it also produces no overflow/underrun event.
  assign w_rd_ok     = bus.rd_en & ~w_empty & ~bus.flush;
  assign w_wr_ok     = bus.wr_en & ~bus.flush & (~w_full | w_rd_ok);
  assign w_wr_reject = bus.wr_en & ~bus.flush & ~w_wr_ok;
  assign w_rd_reject = bus.rd_en & ~bus.flush & w_empty;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A clear in the same cycle as a new event wins over that event.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (bus.clr_status) begin
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_wr_reject) begin
        r_overflow <= 1'b1;
      end
      if (w_rd_reject && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
    end
  end

  assign bus.dout         = r_mem[r_rd_ptr];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_count >= c_AF);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire
